// File: rtl/ksa.sv
// RC4 key-scheduling engine: walks i over a 256x8 S-box RAM, updating j and
// swapping S[i]/S[j] through a single-port synchronous RAM, six cycles per i.
module ksa (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] key,
  output logic        rdy,
  output logic [7:0]  addr,
  input  logic [7:0]  rddata,
  output logic [7:0]  wrdata,
  output logic        wren
);

  typedef enum logic [2:0] {
    IDLE, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, DONE
  } state_t;

  state_t      state, state_nx;
  logic [23:0] key_q;
  logic [7:0]  i, j, si, sj;
  logic [7:0]  kbyte, j_new;
  logic        start;

  assign start = en && (state == IDLE || state == DONE);

  always_comb begin
    kbyte = key_q[7:0];
    case (i % 8'd3)
      8'd0:    kbyte = key_q[23:16];
      8'd1:    kbyte = key_q[15:8];
      default: kbyte = key_q[7:0];
    endcase
  end

  // 8-bit sum wraps naturally, giving the mod-256 j update
  assign j_new = j + si + kbyte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = READ_I;
      READ_I:     state_nx = WAIT_I;
      WAIT_I:     state_nx = READ_J;
      READ_J:     state_nx = WAIT_J;
      WAIT_J:     state_nx = WRITE_I;
      WRITE_I:    state_nx = WRITE_J;
      WRITE_J:    state_nx = (i == 8'hFF) ? DONE : READ_I;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdy    = 1'b0;
    addr   = 8'd0;
    wrdata = 8'd0;
    wren   = 1'b0;
    case (state)
      IDLE, DONE: rdy = 1'b1;
      READ_I:     addr = i;
      READ_J:     addr = j_new;
      WRITE_I:    begin addr = i; wrdata = sj; wren = 1'b1; end
      WRITE_J:    begin addr = j; wrdata = si; wren = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 24'd0;
      i     <= 8'd0;
      j     <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
    end else begin
      if (start) begin
        key_q <= key;
        i     <= 8'd0;
        j     <= 8'd0;
      end
      case (state)
        WAIT_I:  si <= rddata;
        READ_J:  j  <= j_new;
        WAIT_J:  sj <= rddata;
        // explicit i==255 test keeps the 8-bit counter from wrapping early
        WRITE_J: if (i != 8'hFF) i <= i + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: synchronous RAM model plus a software RC4 KSA reference that
// predicts every cycle's bus activity and the final S-box contents.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] key;
  logic        rdy;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  logic [7:0]  mem [256];
  logic        ld = 1'b0;
  int          total = 0;
  int          bad = 0;

  ksa dut (
    .clk(clk), .rst_n(rst_n), .en(en), .key(key), .rdy(rdy),
    .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM; ld restores the identity contents
  always @(posedge clk) begin
    if (ld) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else begin
      rddata <= mem[addr];
      if (wren) mem[addr] <= wrdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bus(input logic r, input logic w,
                                      input logic [7:0] a, input logic [7:0] d);
    return {14'd0, r, w, a, d};
  endfunction

  task automatic load_identity();
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  // One schedule from the current RAM contents. hold keeps en high while busy;
  // abort_at >= 0 pulses reset at that busy cycle instead of finishing.
  task automatic run(input logic [23:0] k, input bit hold, input int abort_at);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] jm, t;
    int c;
    for (int n = 0; n < 256; n++) s[n] = mem[n];
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    jm = 8'd0;
    @(negedge clk);
    key = k; en = 1'b1;
    @(negedge clk);
    if (!hold) en = 1'b0;
    key = 24'($urandom);
    c = 0;
    for (int it = 0; it < 256; it++) begin
      for (int ph = 0; ph < 6; ph++) begin
        if (hold && c == 1535) en = 1'b0;
        case (ph)
          0: chk("read_i", bus(rdy, wren, addr, wrdata), bus(0, 0, 8'(it), 0));
          2: begin
               jm = jm + s[it] + kb[it % 3];
               chk("read_j", bus(rdy, wren, addr, wrdata), bus(0, 0, jm, 0));
             end
          4: chk("write_i", bus(rdy, wren, addr, wrdata), bus(0, 1, 8'(it), s[jm]));
          5: begin
               chk("write_j", bus(rdy, wren, addr, wrdata), bus(0, 1, jm, s[it]));
               t = s[it]; s[it] = s[jm]; s[jm] = t;
             end
          default: chk("wait", bus(rdy, wren, addr, wrdata), bus(0, 0, 0, 0));
        endcase
        if (c == abort_at) begin
          rst_n = 1'b0;
          #1 chk("abort_outputs", bus(rdy, wren, addr, wrdata), bus(1, 0, 0, 0));
          @(negedge clk);
          chk("abort_hold", bus(rdy, wren, addr, wrdata), bus(1, 0, 0, 0));
          rst_n = 1'b1;
          return;
        end
        c++;
        @(negedge clk);
      end
    end
    chk("done_rdy", bus(rdy, wren, addr, wrdata), bus(1, 0, 0, 0));
    for (int n = 0; n < 256; n++) chk($sformatf("sbox[%0d]", n), 32'(mem[n]), 32'(s[n]));
  endtask

  initial begin
    logic [23:0] rk;
    rst_n = 1'b0; en = 1'b1; key = 24'h00033C;
    load_identity();
    chk("reset_outputs", bus(rdy, wren, addr, wrdata), bus(1, 0, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_read_i", bus(rdy, wren, addr, wrdata), bus(0, 0, 0, 0));
    en = 1'b0;
    @(negedge clk);
    chk("first_wait_i", bus(rdy, wren, addr, wrdata), bus(0, 0, 0, 0));
    rst_n = 1'b0;
    #1 chk("reset_midrun", bus(rdy, wren, addr, wrdata), bus(1, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;

    // reference key from the plan, then the all-ones wrap case
    load_identity();
    run(24'h00033C, 0, -1);
    load_identity();
    run(24'hFFFFFF, 0, -1);

    // reset during WRITE_I of iteration 10, then a clean restart
    rk = 24'($urandom);
    load_identity();
    run(rk, 0, 10 * 6 + 4);
    load_identity();
    run(rk, 0, -1);

    // en held through the run: no restart while busy; DONE holds until en
    load_identity();
    run(24'($urandom), 1, -1);
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", bus(rdy, wren, addr, wrdata), bus(1, 0, 0, 0));
    end
    run(24'($urandom), 0, -1);

    repeat (2) begin
      load_identity();
      run(24'($urandom), 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/ksa.md
Name: ksa

Overview:
- RC4 Key-Scheduling Algorithm (KSA) engine.
- Walks i = 0..255 over an externally held 256x8 S-box RAM, which the identity initialiser has already filled with S[k] = k. Computes j = j + S[i] + key byte and swaps S[i] and S[j].
- Sits between the S-box init stage and the PRGA stage of the ARC4 decryption datapath. It talks to a single-port synchronous RAM through one addr/rddata/wrdata/wren port.

Parameters:
- none (S-box depth fixed at 256, data width fixed at 8, key fixed at 24 bits / 3 bytes)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  start request; honoured only while rdy=1
- key  input  24  cipher key; byte0 = key[23:16], byte1 = key[15:8], byte2 = key[7:0]
- rdy  output  1  1 = idle/done and able to accept en; 0 = busy
- addr  output  8  S-box RAM address
- rddata  input  8  S-box RAM read data, valid one cycle after the address is presented
- wrdata  output  8  S-box RAM write data
- wren  output  1  S-box RAM write enable

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, rdy=1, addr=0, wrdata=0, wren=0.
  - Internal registers i=0, j=0, si=0, sj=0.
  - Reset asserted mid-operation aborts immediately to IDLE. Partial swaps already written to the RAM are not undone.
- Start handshake:
  - In IDLE or DONE, en=1 at a rising edge latches key into an internal register and clears i and j to 0.
  - The next state is READ_I, so rdy drops in the cycle after en is sampled.
  - en is ignored while rdy=0.
- Output defaults: unless a state says otherwise, addr=0, wrdata=0, wren=0, rdy=0. All outputs are registered or decoded from state so they are stable for the whole cycle.
- Per-iteration sequence, six cycles each, fixed:
  - READ_I: addr=i, wren=0.
  - WAIT_I: addr=0, wren=0. At the end of this cycle, capture si <= rddata (= S[i]).
  - READ_J: j_new = (j + si + keybyte(i mod 3)) mod 256, using 8-bit wrap-around addition. Register j <= j_new at the end of the cycle. addr=j_new during this cycle, wren=0.
  - WAIT_J: addr=0, wren=0. At the end of this cycle, capture sj <= rddata (= S[j]).
  - WRITE_I: addr=i, wrdata=sj, wren=1.
  - WRITE_J: addr=j, wrdata=si, wren=1. At the end of this cycle:
    - if i==255, go to DONE;
    - otherwise i <= i+1 and go to READ_I.
- keybyte selection: i mod 3 = 0 -> key[23:16]; 1 -> key[15:8]; 2 -> key[7:0]. The key length is fixed at 3.
- i == j: both writes still occur with the same address. Because WRITE_J writes si, the cell ends with its original value.
- DONE: rdy=1, addr=0, wrdata=0, wren=0. Holds until en=1, which restarts the schedule with j reset to 0.
- Total latency: 256 x 6 = 1536 cycles from the first READ_I to DONE.
- The i counter must not overflow before 255 is processed. Use a 9-bit counter or an explicit i==255 test.
- IDLE and DONE are encoded separately, but both present rdy=1. IDLE is equivalent to DONE for handshake purposes.

Test Plan:
- Reset then release with en=1:
  - during reset: rdy=1, addr=0, wrdata=0, wren=0;
  - next cycle: READ_I with addr=0, rdy=0, wren=0, wrdata=0.
- Key 24'h00033C, RAM preloaded with S[k]=k:
  - i=0: j=0; WRITE_I addr=0 wrdata=0, then WRITE_J addr=0 wrdata=0.
  - i=1: READ_J addr=4; WRITE_I addr=1 wrdata=4, then WRITE_J addr=4 wrdata=1.
  - i=2: READ_J addr=0x42.
- Full run with a RAM model:
  - Every WRITE_I carries S[j] and every WRITE_J carries the old S[i].
  - Wait states show addr=0 and wrdata=0.
  - The final RAM equals a software RC4 KSA for key 00 03 3C.
  - rdy returns to 1 after exactly 1536 busy cycles.
- Key 24'hFFFFFF: j additions wrap mod 256 without error. Final S matches the software model.
- Reset asserted during WRITE_I of iteration 10:
  - outputs go to reset values immediately.
  - A subsequent en restarts from i=0, j=0.
- en held high through the run and pulsed again in DONE:
  - no restart while busy.
  - A new run starts from DONE and j starts at 0.
